// File: rtl/inst_issue_buffer_pkg.sv
// Shared constants and types for the instruction issue buffer.
// Optional build macro ISSUE_STATS_EN adds issue statistics counters to the top.
package inst_issue_buffer_pkg;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int EXC_W = 5;

  localparam logic SINGLE_ISSUE = 1'b0;
  localparam logic DUAL_ISSUE   = 1'b1;

  localparam logic [EXC_W-1:0] EXC_NONE = '0;

  // Occupancy state encodings (legacy-compatible constants)
  localparam logic [1:0] IBUF_S_EMPTY = 2'd0;
  localparam logic [1:0] IBUF_S_ONE   = 2'd1;
  localparam logic [1:0] IBUF_S_PAIR  = 2'd2;

  typedef struct packed {
    logic [31:0]      inst;
    logic [31:0]      addr;
    logic [EXC_W-1:0] exc;
  } entry_t;

  // Occupancy state implied by an entry count
  function automatic logic [1:0] occ_state(input logic [PTR_W:0] cnt);
    if (cnt == '0) return IBUF_S_EMPTY;
    if (cnt == (PTR_W+1)'(1)) return IBUF_S_ONE;
    return IBUF_S_PAIR;
  endfunction

endpackage

// File: rtl/inst_issue_buffer_if.sv
// Fetch/ID-facing bundle of the issue buffer. master = fetch+ID side, slave = buffer.
interface inst_issue_buffer_if;
  import inst_issue_buffer_pkg::*;

  logic             flush;
  logic [1:0]       push_valid;
  logic [31:0]      push_inst_a, push_inst_b;
  logic [31:0]      push_addr_a, push_addr_b;
  logic [EXC_W-1:0] push_exc_a, push_exc_b;
  logic             push_ready;
  logic             id_re;
  logic             issue_mode;
  logic             iss_valid1, iss_valid2;
  logic [31:0]      iss_inst1, iss_inst2;
  logic [31:0]      iss_addr1, iss_addr2;
  logic [EXC_W-1:0] iss_exc1, iss_exc2;
  logic [PTR_W:0]   buf_count;

  modport master (
    output flush, push_valid, push_inst_a, push_inst_b, push_addr_a, push_addr_b,
           push_exc_a, push_exc_b, id_re, issue_mode,
    input  push_ready, iss_valid1, iss_valid2, iss_inst1, iss_inst2,
           iss_addr1, iss_addr2, iss_exc1, iss_exc2, buf_count
  );

  modport slave (
    input  flush, push_valid, push_inst_a, push_inst_b, push_addr_a, push_addr_b,
           push_exc_a, push_exc_b, id_re, issue_mode,
    output push_ready, iss_valid1, iss_valid2, iss_inst1, iss_inst2,
           iss_addr1, iss_addr2, iss_exc1, iss_exc2, buf_count
  );

endinterface

// File: rtl/inst_issue_buffer_mem.sv
// Circular entry store: two write ports (wa, wa+1) and two async read ports (ra, ra+1).
// Index wrap is implicit in the PTR_W-bit address arithmetic.
module inst_issue_buffer_mem
  import inst_issue_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             we_a,
  input  logic             we_b,
  input  logic [PTR_W-1:0] wa,
  input  entry_t           wdata_a,
  input  entry_t           wdata_b,
  input  logic [PTR_W-1:0] ra,
  output entry_t           rdata_a,
  output entry_t           rdata_b
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wa_b;
  logic [PTR_W-1:0] ra_b;

  assign wa_b = wa + PTR_W'(1);
  assign ra_b = ra + PTR_W'(1);

  // Write the one or two incoming entries
  // NOTE: storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (we_a) mem_q[wa]   <= wdata_a;
    if (we_b) mem_q[wa_b] <= wdata_b;
  end

  assign rdata_a = mem_q[ra];
  assign rdata_b = mem_q[ra_b];

endmodule

// File: rtl/inst_issue_buffer.sv
// Decoupling buffer between fetch (up to 2 pushes/cycle) and dual-issue ID (1-2 retires/cycle).
// Build macro ISSUE_STATS_EN adds stat_dual/stat_single/stat_bubble saturating counters.
module inst_issue_buffer
  import inst_issue_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  inst_issue_buffer_if.slave  bus
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]         stat_dual,
  output logic [31:0]         stat_single,
  output logic [31:0]         stat_bubble
`endif
);

  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [PTR_W+1:0] count_sum;
  logic [1:0]       npush, npop;
  logic             valid1, valid2, accept;
  entry_t           slot1, slot2, wdata_a, wdata_b;

  // Room for two is judged on the registered count only, ignoring this cycle's pop
  assign bus.push_ready = (count_q <= READY_MAX);
  assign accept         = bus.push_ready && !bus.flush;

  assign valid1 = (state_q != IBUF_S_EMPTY) && !bus.flush;
  assign valid2 = (state_q == IBUF_S_PAIR)  && !bus.flush;

  // Number of entries accepted from fetch this cycle
  // NOTE: defaulting every always_comb output first keeps the block free of latches.
  always_comb begin
    npush = 2'd0;
    if (accept) npush = {1'b0, bus.push_valid[0]} + {1'b0, bus.push_valid[1]};
  end

  // Number of entries retired by ID this cycle; slot2 never goes without slot1
  always_comb begin
    npop = 2'd0;
    if (bus.id_re && !bus.flush) begin
      if (valid2 && bus.issue_mode == DUAL_ISSUE) npop = 2'd2;
      else if (valid1)                            npop = 2'd1;
    end
  end

  // One extra bit so both overflow and underflow show up as a value above DEPTH
  assign count_sum = {1'b0, count_q} + (PTR_W+2)'(npush) - (PTR_W+2)'(npop);

  // Pointer/count update; flush wins over any push or pop
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(npop);
    wr_ptr_d = wr_ptr_q + PTR_W'(npush);
    count_d  = count_sum[PTR_W:0];
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    state_d = occ_state(count_d);
  end

  // Occupancy registers
  // NOTE: sequential state is assigned non-blocking so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IBUF_S_EMPTY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  assign wdata_a = '{inst: bus.push_inst_a, addr: bus.push_addr_a, exc: bus.push_exc_a};
  assign wdata_b = '{inst: bus.push_inst_b, addr: bus.push_addr_b, exc: bus.push_exc_b};

  inst_issue_buffer_mem u_mem (
    .clk     (clk),
    .we_a    (accept && bus.push_valid[0]),
    .we_b    (accept && bus.push_valid[1]),
    .wa      (wr_ptr_q),
    .wdata_a (wdata_a),
    .wdata_b (wdata_b),
    .ra      (rd_ptr_q),
    .rdata_a (slot1),
    .rdata_b (slot2)
  );

  assign bus.iss_valid1 = valid1;
  assign bus.iss_valid2 = valid2;
  assign bus.iss_inst1  = slot1.inst;
  assign bus.iss_addr1  = slot1.addr;
  assign bus.iss_exc1   = slot1.exc;
  assign bus.iss_inst2  = slot2.inst;
  assign bus.iss_addr2  = slot2.addr;
  assign bus.iss_exc2   = slot2.exc;
  assign bus.buf_count  = count_q;

  // Occupancy can never leave [0, DEPTH]
  count_in_range: assert property (@(posedge clk) disable iff (!resetn)
    count_sum <= (PTR_W+2)'(DEPTH));

`ifdef ISSUE_STATS_EN
  // Saturating issue statistics, sampled on every cycle ID is not stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_dual   <= '0;
      stat_single <= '0;
      stat_bubble <= '0;
    end else if (bus.id_re) begin
      case (npop)
        2'd2:    if (stat_dual   != '1) stat_dual   <= stat_dual   + 32'd1;
        2'd1:    if (stat_single != '1) stat_single <= stat_single + 32'd1;
        default: if (stat_bubble != '1) stat_bubble <= stat_bubble + 32'd1;
      endcase
    end
  end
`endif

endmodule
